i2c_master_slave: RTL and testbench
===================================

Name: i2c_master_slave

Overview:
- Self-contained I2C subsystem with one single-master I2C controller and one 7-bit-address I2C slave that owns an 8-bit LED register.
- Both share an open-drain SDA line and a master-driven SCL; SDA has an external pull-up.
- A host issues START, byte and STOP commands to the master. The slave latches written data onto LED and returns LED on reads.

Parameters:
- SCL_QTR, 250: system clocks per quarter SCL bit period (100 kHz SCL at 100 MHz clk).
- SLAVE_ADDR, 7'h24: 7-bit address the slave answers to (write byte 0x48, read byte 0x49).

Ports:
- clk input 1: system clock, all logic on rising edge.
- reset input 1: asynchronous, active-low reset.
- I2C_En input 1: master enable; commands are ignored while 0.
- I2C_Start input 1: START request, sampled in IDLE or HOLD.
- I2C_Stop input 1: STOP request, sampled in HOLD; has priority over I2C_Start.
- tx_data input 8: byte to send, latched when a byte begins.
- rx_data output 8: last byte read from the bus.
- ready output 1: high in IDLE and HOLD (master accepts a command).
- tx_done output 1: one-cycle pulse after the 8th bit of a transmitted byte.
- rx_done output 1: one-cycle pulse after the 8th bit of a received byte.
- SDA inout 1: open-drain data line; driven only 0 or Z.
- SCL output 1: I2C clock, push-pull from the master; idles high.
- LED output 8: slave data register.

Behaviour:
- Reset (asynchronous, active-low):
  - Master goes to IDLE with SCL=1, SDA released, ready=1, tx_done=0, rx_done=0, rx_data=0.
  - Slave goes to IDLE with SDA released and LED=0.
  - Applies immediately, including mid-byte.
- Timing: each bit is 4 quarters of SCL_QTR clocks.
  - Q1: SCL low, master/slave update SDA.
  - Q2, Q3: SCL high; receivers sample SDA at the end of Q2.
  - Q4: SCL low.
- Master states: IDLE, START1, START2, DATA(Q1-Q4 x 8 bits), ACK(Q1-Q4), HOLD, STOP1, STOP2, STOP3.
  - IDLE: I2C_En & I2C_Start -> START1. START1: SDA=1, SCL=1. START2: SDA=0, SCL=1. Then tx_data is latched and the byte begins with SCL low.
  - First byte after any START is the address byte; its bit0 sets direction (0=write, 1=read) for the following bytes.
  - Write byte: MSB first; tx_done pulses at the end of bit 7 Q4. ACK phase: SDA released, slave ACK sampled at the end of Q2.
  - Read byte: SDA released and 8 bits sampled MSB first; rx_data is updated and rx_done pulses at the end of bit 7 Q4. ACK phase: master drives 0 (ACK), or releases (NACK) if I2C_Stop=1 at ACK Q1.
  - After ACK -> HOLD with SCL low and ready=1. Priority: I2C_Stop -> STOP1; else I2C_Start -> START1 (repeated start, SDA released first); else I2C_En -> latch tx_data and start next byte; else stay.
  - STOP1: SCL low, SDA=0. STOP2: SCL high, SDA=0. STOP3: SCL high, SDA released -> IDLE.
  - I2C_En=0 in HOLD holds the bus until I2C_Stop arrives.
- Slave:
  - Two-flop synchronizes SCL and SDA.
  - START = SDA falling while SCL high; STOP = SDA rising while SCL high. Either restarts the slave FSM at any point.
  - Samples on SCL rising, changes SDA only while SCL low.
  - Address match: pulls SDA low for the ACK bit. Mismatch: NACK and ignore the bus until the next START/STOP.
  - Write: each data byte is loaded into LED at the 8th bit and ACKed.
  - Read: shifts out LED MSB first; after a master NACK, releases SDA and waits for STOP/START.
- Master and slave never drive SDA=1. A 1 is produced by the pull-up.

Optional Feature:
- Macro I2C_NACK_STOP_EN.
- When defined: if the master samples NACK after a write byte, it skips HOLD and enters STOP1 automatically, with ready low until IDLE.
- When undefined: a NACK is ignored and the master enters HOLD as for an ACK.

Test Plan:
- Reset then release -> SCL=1, SDA=1 (pull-up), ready=1, LED=0x00, no tx_done/rx_done pulses.
- START, byte 0x48, byte 0x01, STOP -> SDA low during both ACK bits, two tx_done pulses, STOP seen, LED=0x01, ready=1.
- START, 0x50, 0xFF, STOP -> address NACK (SDA high in ACK bit), LED unchanged at 0x01.
- Write 0x48/0xA5 then STOP; START, 0x49, read one byte with I2C_Stop=1 at ACK (NACK), STOP -> rx_data=0xA5, one rx_done pulse.
- Assert reset mid address byte -> SCL=1, SDA released immediately; a following 0x48/0x3C write gives LED=0x3C.
- I2C_Start pulse with I2C_En=0 -> no bus activity, ready stays 1.

Source files
------------

// File: rtl/i2c_master_slave.sv
// I2C master plus 7-bit slave with LED register; I2C_NACK_STOP_EN: auto-STOP on NACKed write byte.
// One bit = 4*SCL_QTR clocks; host may issue commands only while ready=1, otherwise they are ignored.
module i2c_master_slave #(
  parameter int unsigned SCL_QTR    = 250,
  parameter logic [6:0]  SLAVE_ADDR = 7'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I2C_En,
  input  logic       I2C_Start,
  input  logic       I2C_Stop,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       ready,
  output logic       tx_done,
  output logic       rx_done,
  inout  wire        SDA,
  output logic       SCL,
  output logic [7:0] LED
);

  localparam int QW = (SCL_QTR > 1) ? $clog2(SCL_QTR) : 1;

  typedef enum logic [3:0] {
    M_IDLE, M_START1, M_START2, M_DATA, M_ACK, M_HOLD, M_STOP1, M_STOP2, M_STOP3
  } m_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_WAIT, S_ACK_DRV, S_WR, S_RD, S_RD_ACK, S_RD_LOAD
  } s_state_t;

  logic sda_in;

  m_state_t      m_state_q, m_state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          is_addr_q, is_addr_d;
  logic          rd_q, rd_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d;
  logic          m_oe_q, m_oe_d;
  logic          ready_q, ready_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_done_q, rx_done_d;
  logic          tick, wr_byte, start_byte, first_byte;

  s_state_t      s_state_q, s_state_d;
  logic          scl_m_q, scl_s_q, scl_p_q;
  logic          sda_m_q, sda_s_q, sda_p_q;
  logic [7:0]    s_sh_q, s_sh_d;
  logic [2:0]    s_cnt_q, s_cnt_d;
  logic          s_rw_q, s_rw_d;
  logic          s_oe_q, s_oe_d;
  logic [7:0]    led_q, led_d;
  logic          scl_rise, scl_fall, start_det, stop_det, load_rd;
  logic [7:0]    s_rx_byte;

  // Open-drain bus: either side can only pull low, the pull-up makes a 1.
  assign SDA    = (m_oe_q | s_oe_q) ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  assign SCL     = scl_q;
  assign ready   = ready_q;
  assign tx_done = tx_done_q;
  assign rx_done = rx_done_q;
  assign rx_data = rx_data_q;
  assign LED     = led_q;

  assign tick    = (qcnt_q == QW'(SCL_QTR - 1));
  assign wr_byte = is_addr_q | ~rd_q;

  always_comb begin
    m_state_d  = m_state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    is_addr_d  = is_addr_q;
    rd_d       = rd_q;
    nack_d     = nack_q;
    scl_d      = scl_q;
    m_oe_d     = m_oe_q;
    tx_done_d  = 1'b0;
    rx_done_d  = 1'b0;
    start_byte = 1'b0;
    first_byte = 1'b0;

    if (m_state_q == M_IDLE || m_state_q == M_HOLD) qcnt_d = '0;
    else qcnt_d = tick ? '0 : qcnt_q + 1'b1;

    case (m_state_q)
      M_IDLE: begin
        scl_d  = 1'b1;
        m_oe_d = 1'b0;
        if (I2C_En && I2C_Start) m_state_d = M_START1;
      end
      M_START1: if (tick) begin
        m_state_d = M_START2;
        m_oe_d    = 1'b1;
      end
      M_START2: if (tick) begin
        start_byte = 1'b1;
        first_byte = 1'b1;
      end
      M_DATA: if (tick) begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0: scl_d = 1'b1;
          2'd1: if (!wr_byte) rx_sh_d = {rx_sh_q[6:0], sda_in};
          2'd2: scl_d = 1'b0;
          2'd3: begin
            if (bit_q == 3'd0) begin
              m_state_d = M_ACK;
              if (wr_byte) begin
                tx_done_d = 1'b1;
                m_oe_d    = 1'b0;
              end else begin
                rx_done_d = 1'b1;
                rx_data_d = rx_sh_q;
                m_oe_d    = ~I2C_Stop;
              end
            end else begin
              bit_d   = bit_q - 3'd1;
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              m_oe_d  = wr_byte & ~tx_sh_q[6];
            end
          end
        endcase
      end
      M_ACK: begin
        // The host's I2C_Stop during ACK Q1 turns the read ACK into a NACK.
        if (phase_q == 2'd0 && !wr_byte) m_oe_d = ~I2C_Stop;
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: nack_d = sda_in;
            2'd2: scl_d = 1'b0;
            2'd3: begin
`ifdef I2C_NACK_STOP_EN
              if (wr_byte && nack_q) begin
                m_state_d = M_STOP1;
                m_oe_d    = 1'b1;
              end else
`endif
              begin
                m_state_d = M_HOLD;
                m_oe_d    = 1'b0;
              end
            end
          endcase
        end
      end
      M_HOLD: begin
        if (I2C_Stop) begin
          m_state_d = M_STOP1;
          m_oe_d    = 1'b1;
          scl_d     = 1'b0;
        end else if (I2C_En && I2C_Start) begin
          m_state_d = M_START1;
          m_oe_d    = 1'b0;
          scl_d     = 1'b1;
        end else if (I2C_En) begin
          start_byte = 1'b1;
        end
      end
      M_STOP1: if (tick) begin
        m_state_d = M_STOP2;
        scl_d     = 1'b1;
      end
      M_STOP2: if (tick) begin
        m_state_d = M_STOP3;
        m_oe_d    = 1'b0;
      end
      M_STOP3: if (tick) m_state_d = M_IDLE;
      default: m_state_d = M_IDLE;
    endcase

    if (start_byte) begin
      m_state_d = M_DATA;
      tx_sh_d   = tx_data;
      phase_d   = 2'd0;
      bit_d     = 3'd7;
      scl_d     = 1'b0;
      is_addr_d = first_byte;
      if (first_byte) rd_d = tx_data[0];
      m_oe_d    = (first_byte | ~rd_q) & ~tx_data[7];
    end

    ready_d = (m_state_d == M_IDLE) || (m_state_d == M_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state_q <= M_IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd7;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      is_addr_q <= 1'b0;
      rd_q      <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      m_oe_q    <= 1'b0;
      ready_q   <= 1'b1;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      m_state_q <= m_state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      is_addr_q <= is_addr_d;
      rd_q      <= rd_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      m_oe_q    <= m_oe_d;
      ready_q   <= ready_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
    end
  end

  // Requiring SCL high on two consecutive samples keeps a simultaneous SCL/SDA
  // change from being mistaken for a START or STOP.
  assign scl_rise  = scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q & scl_p_q;
  assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign s_rx_byte = {s_sh_q[6:0], sda_s_q};

  always_comb begin
    s_state_d = s_state_q;
    s_sh_d    = s_sh_q;
    s_cnt_d   = s_cnt_q;
    s_rw_d    = s_rw_q;
    s_oe_d    = s_oe_q;
    led_d     = led_q;
    load_rd   = 1'b0;

    if (start_det) begin
      s_state_d = S_ADDR;
      s_cnt_d   = 3'd0;
      s_oe_d    = 1'b0;
    end else if (stop_det) begin
      s_state_d = S_IDLE;
      s_oe_d    = 1'b0;
    end else begin
      case (s_state_q)
        S_ADDR: if (scl_rise) begin
          s_sh_d  = s_rx_byte;
          s_cnt_d = s_cnt_q + 3'd1;
          if (s_cnt_q == 3'd7) begin
            if (s_rx_byte[7:1] == SLAVE_ADDR) begin
              s_rw_d    = s_rx_byte[0];
              s_state_d = S_ACK_WAIT;
            end else begin
              s_state_d = S_IDLE;
            end
          end
        end
        S_ACK_WAIT: if (scl_fall) begin
          s_oe_d    = 1'b1;
          s_state_d = S_ACK_DRV;
        end
        S_ACK_DRV: if (scl_fall) begin
          if (s_rw_q) begin
            load_rd = 1'b1;
          end else begin
            s_oe_d    = 1'b0;
            s_cnt_d   = 3'd0;
            s_state_d = S_WR;
          end
        end
        S_WR: if (scl_rise) begin
          s_sh_d  = s_rx_byte;
          s_cnt_d = s_cnt_q + 3'd1;
          if (s_cnt_q == 3'd7) begin
            led_d     = s_rx_byte;
            s_state_d = S_ACK_WAIT;
          end
        end
        S_RD: if (scl_fall) begin
          if (s_cnt_q == 3'd7) begin
            s_oe_d    = 1'b0;
            s_state_d = S_RD_ACK;
          end else begin
            s_cnt_d = s_cnt_q + 3'd1;
            s_sh_d  = {s_sh_q[6:0], 1'b0};
            s_oe_d  = ~s_sh_q[6];
          end
        end
        S_RD_ACK: if (scl_rise) s_state_d = sda_s_q ? S_IDLE : S_RD_LOAD;
        S_RD_LOAD: if (scl_fall) load_rd = 1'b1;
        default: s_state_d = S_IDLE;
      endcase
    end

    if (load_rd) begin
      s_sh_d    = led_q;
      s_oe_d    = ~led_q[7];
      s_cnt_d   = 3'd0;
      s_state_d = S_RD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state_q <= S_IDLE;
      scl_m_q   <= 1'b1;
      scl_s_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_m_q   <= 1'b1;
      sda_s_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      s_sh_q    <= 8'h00;
      s_cnt_q   <= 3'd0;
      s_rw_q    <= 1'b0;
      s_oe_q    <= 1'b0;
      led_q     <= 8'h00;
    end else begin
      s_state_q <= s_state_d;
      scl_m_q   <= scl_q;
      scl_s_q   <= scl_m_q;
      scl_p_q   <= scl_s_q;
      sda_m_q   <= sda_in;
      sda_s_q   <= sda_m_q;
      sda_p_q   <= sda_s_q;
      s_sh_q    <= s_sh_d;
      s_cnt_q   <= s_cnt_d;
      s_rw_q    <= s_rw_d;
      s_oe_q    <= s_oe_d;
      led_q     <= led_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_slave.sv
// Bench for i2c_master_slave: host driver, cycle-sampled bus monitor and frame scoreboard.
module tb_i2c_master_slave;

  localparam int QTR = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       I2C_En = 1'b0;
  logic       I2C_Start = 1'b0;
  logic       I2C_Stop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic [7:0] LED;
  logic       ready, tx_done, rx_done, SCL;
  wire        sda_w;

  pullup (sda_w);

  i2c_master_slave #(.SCL_QTR(QTR), .SLAVE_ADDR(7'h24)) dut (
    .clk(clk), .reset(reset), .I2C_En(I2C_En), .I2C_Start(I2C_Start),
    .I2C_Stop(I2C_Stop), .tx_data(tx_data), .rx_data(rx_data), .ready(ready),
    .tx_done(tx_done), .rx_done(rx_done), .SDA(sda_w), .SCL(SCL), .LED(LED)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dat;
    logic       ack;
  } frame_t;

  frame_t     exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         tx_cnt = 0, rx_cnt = 0, start_cnt = 0, stop_cnt = 0, bit_cnt = 0;
  logic [8:0] mon_sh = '0;
  logic       scl_p = 1'b1, sda_p = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: frames of 8 data bits plus the ACK bit, sampled on SCL rising.
  always @(negedge clk) begin
    frame_t f;
    if (!reset) begin
      bit_cnt = 0;
      scl_p   = 1'b1;
      sda_p   = 1'b1;
    end else begin
      if (tx_done) tx_cnt++;
      if (rx_done) rx_cnt++;
      if (SCL && scl_p && sda_p && !sda_w) begin
        start_cnt++;
        bit_cnt = 0;
      end else if (SCL && scl_p && !sda_p && sda_w) begin
        stop_cnt++;
        bit_cnt = 0;
      end else if (SCL && !scl_p) begin
        mon_sh = {mon_sh[7:0], sda_w};
        bit_cnt++;
        if (bit_cnt == 9) begin
          bit_cnt = 0;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            check("frame_dat", mon_sh[8:1], f.dat);
            check("frame_ack", mon_sh[0], f.ack);
          end
        end
      end
      scl_p = SCL;
      sda_p = sda_w;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 5000);
    if (!ready) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic start_cmd(input logic [7:0] addr, input logic ack);
    @(negedge clk);
    tx_data   = addr;
    I2C_En    = 1'b1;
    I2C_Start = 1'b1;
    exp_q.push_back(frame_t'{dat: addr, ack: ack});
    @(negedge clk);
    I2C_En    = 1'b0;
    I2C_Start = 1'b0;
    wait_ready("start");
  endtask

  task automatic byte_cmd(input logic [7:0] d, input logic ack);
    @(negedge clk);
    tx_data = d;
    I2C_En  = 1'b1;
    exp_q.push_back(frame_t'{dat: d, ack: ack});
    @(negedge clk);
    I2C_En = 1'b0;
    wait_ready("byte");
  endtask

  task automatic stop_cmd();
    @(negedge clk);
    I2C_Stop = 1'b1;
    @(negedge clk);
    I2C_Stop = 1'b0;
    wait_ready("stop");
  endtask

  // Read one byte with I2C_Stop held through ACK: master NACKs, then STOPs from HOLD.
  task automatic read_nack_stop(input logic [7:0] exp);
    @(negedge clk);
    I2C_En = 1'b1;
    exp_q.push_back(frame_t'{dat: exp, ack: 1'b1});
    @(negedge clk);
    I2C_En   = 1'b0;
    I2C_Stop = 1'b1;
    wait_ready("read");
    @(negedge clk);
    I2C_Stop = 1'b0;
    wait_ready("read_stop");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int s0, nr, nb;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_scl", SCL, 1);
    check("rst_sda", sda_w, 1);
    check("rst_ready", ready, 1);
    check("rst_led", LED, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_done", tx_cnt, 0);
    check("rst_rx_done", rx_cnt, 0);

    // Addressed write
    tx_cnt = 0;
    s0 = stop_cnt;
    start_cmd(8'h48, 1'b0);
    byte_cmd(8'h01, 1'b0);
    stop_cmd();
    check("wr_stop_seen", stop_cnt - s0, 1);
    check("wr_tx_done", tx_cnt, 2);
    check("wr_led", LED, 8'h01);
    check("wr_ready", ready, 1);

    // Wrong address: NACK and data ignored
    start_cmd(8'h50, 1'b1);
    byte_cmd(8'hFF, 1'b1);
    stop_cmd();
    check("nack_led", LED, 8'h01);

    // Write then read back with NACK
    start_cmd(8'h48, 1'b0);
    byte_cmd(8'hA5, 1'b0);
    stop_cmd();
    rx_cnt = 0;
    s0 = stop_cnt;
    start_cmd(8'h49, 1'b0);
    read_nack_stop(8'hA5);
    check("rd_rx_data", rx_data, 8'hA5);
    check("rd_rx_done", rx_cnt, 1);
    check("rd_stop_seen", stop_cnt - s0, 1);
    check("rd_led", LED, 8'hA5);

    // Reset in Q1 of the 4th address bit (a 0), where SCL and SDA are both low
    @(negedge clk);
    tx_data   = 8'h48;
    I2C_En    = 1'b1;
    I2C_Start = 1'b1;
    @(negedge clk);
    I2C_En    = 1'b0;
    I2C_Start = 1'b0;
    repeat (2 * QTR + 3 * 4 * QTR + 2) @(negedge clk);
    check("pre_rst_scl", SCL, 0);
    check("pre_rst_sda", sda_w, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_scl", SCL, 1);
    check("mid_rst_sda", sda_w, 1);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_led", LED, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    start_cmd(8'h48, 1'b0);
    byte_cmd(8'h3C, 1'b0);
    stop_cmd();
    check("post_rst_led", LED, 8'h3C);

    // START with I2C_En low must be ignored
    s0 = start_cnt;
    nr = 0;
    nb = 0;
    @(negedge clk);
    I2C_Start = 1'b1;
    @(negedge clk);
    I2C_Start = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (!ready) nr++;
      if (!SCL || sda_w !== 1'b1) nb++;
    end
    check("dis_ready_low_cycles", nr, 0);
    check("dis_bus_activity", nb, 0);
    check("dis_start_seen", start_cnt - s0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
